xc_malu_long_ctrl: RTL and testbench

//  Sequencer for the multi-precision ALU long-arithmetic datapath (madd/msub/

---
 rtl/xc_malu_long_ctrl.sv | 164 ++++++++++++++++
 tb/tb_xc_malu_long_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_long_ctrl.sv
// Sequencer for the multi-precision ALU long-arithmetic datapath
// (madd/msub/macc/mmul). Owns the accumulator, carry and step counter and
// decodes the one-hot fsm_* step flags that steer the shared packed adder.
// Optional feature macro: XC_MALU_MUL_EARLY_EXIT_EN lets the multiply loop
// leave as soon as the remaining multiplier bits are all zero.
module xc_malu_long_ctrl #(
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic        flush,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic [63:0] dp_n_acc,
  input  logic        dp_n_carry,
  input  logic        dp_ready,
  input  logic [63:0] mul_n_acc,
  input  logic        mul_rem_zero,
  output logic        fsm_init,
  output logic        fsm_msub_1,
  output logic        fsm_macc_1,
  output logic        fsm_mmul_1,
  output logic        fsm_mmul_2,
  output logic        fsm_done,
  output logic [63:0] acc,
  output logic        carry,
  output logic [5:0]  count,
  output logic        ready
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_STEPS - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MUL_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSUB_1,
    S_MACC_1,
    S_MMUL_1,
    S_MMUL_2,
    S_MMUL_3,
    S_DONE
  } state_t;

  state_t        state, n_state;
  logic [63:0]   n_acc;
  logic          n_carry;
  logic [CW-1:0] n_count;
  logic          abort;
  logic          any_uop;
  logic          mul_exit;

  assign abort   = flush | ~valid;
  assign any_uop = uop_madd | uop_msub | uop_macc | uop_mmul;

`ifdef XC_MALU_MUL_EARLY_EXIT_EN
  assign mul_exit = (count >= CNT_LAST) | mul_rem_zero;
`else
  logic unused_rem_zero;
  assign unused_rem_zero = mul_rem_zero;
  assign mul_exit        = (count >= CNT_LAST);
`endif

  // Step flags decode straight from the state register.
  assign fsm_init   = (state == S_IDLE) & valid;
  assign fsm_msub_1 = (state == S_MSUB_1);
  assign fsm_macc_1 = (state == S_MACC_1);
  assign fsm_mmul_1 = (state == S_MMUL_1);
  assign fsm_mmul_2 = (state == S_MMUL_2);
  assign fsm_done   = (state == S_DONE);

  // State and datapath register updates.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= S_IDLE;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      state <= n_state;
      acc   <= n_acc;
      carry <= n_carry;
      count <= n_count;
    end
  end

  // Next-state, register-load and ready decode.
  always_comb begin
    n_state = state;
    n_acc   = acc;
    n_carry = carry;
    n_count = count;
    ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid && !flush && any_uop) begin
          n_acc   = dp_n_acc;
          n_carry = dp_n_carry;
          n_count = '0;
          if (uop_madd) begin
            ready = dp_ready;
          end else if (uop_msub) begin
            n_state = S_MSUB_1;
          end else if (uop_macc) begin
            n_state = S_MACC_1;
          end else begin
            n_acc   = '0;
            n_state = S_MMUL_1;
          end
        end
      end
      S_MSUB_1, S_MACC_1: begin
        if (abort) begin
          n_state = S_IDLE;
        end else begin
          n_acc   = dp_n_acc;
          n_carry = dp_n_carry;
          n_state = S_DONE;
        end
      end
      S_MMUL_1: begin
        if (abort) begin
          n_state = S_IDLE;
        end else begin
          n_acc = mul_n_acc;
          if (count < CNT_SAT) begin
            n_count = count + CW'(1);
          end
          if (mul_exit) begin
            n_state = S_MMUL_2;
          end
        end
      end
      S_MMUL_2: begin
        if (abort) begin
          n_state = S_IDLE;
        end else begin
          n_acc   = dp_n_acc;
          n_carry = dp_n_carry;
          n_state = S_MMUL_3;
        end
      end
      S_MMUL_3: begin
        if (abort) begin
          n_state = S_IDLE;
        end else begin
          n_acc   = dp_n_acc;
          n_state = S_DONE;
        end
      end
      S_DONE: begin
        ready   = ~abort;
        n_state = S_IDLE;
      end
      default: begin
        n_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xc_malu_long_ctrl.sv
// Scoreboard bench for xc_malu_long_ctrl: stimulus pushes expected results,
// a monitor pops and compares them whenever ready pulses.
module tb_xc_malu_long_ctrl;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        valid, flush;
  logic        uop_madd, uop_msub, uop_macc, uop_mmul;
  logic [63:0] dp_n_acc;
  logic        dp_n_carry;
  logic        dp_ready;
  logic [63:0] mul_n_acc;
  logic        mul_rem_zero;
  logic        fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done;
  logic [63:0] acc;
  logic        carry;
  logic [5:0]  count;
  logic        ready;

  // stub datapath controls
  logic [63:0] v0, v1, v2, v3;
  logic        c_in;
  logic        rz_mode, rz_const;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [63:0] acc;
    logic        carry;
    logic [5:0]  cnt;
    int          lat;
    int          start;
  } exp_t;
  exp_t sb[$];

  xc_malu_long_ctrl #(.MUL_STEPS(32)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .flush(flush),
    .uop_madd(uop_madd), .uop_msub(uop_msub), .uop_macc(uop_macc), .uop_mmul(uop_mmul),
    .dp_n_acc(dp_n_acc), .dp_n_carry(dp_n_carry), .dp_ready(dp_ready),
    .mul_n_acc(mul_n_acc), .mul_rem_zero(mul_rem_zero),
    .fsm_init(fsm_init), .fsm_msub_1(fsm_msub_1), .fsm_macc_1(fsm_macc_1),
    .fsm_mmul_1(fsm_mmul_1), .fsm_mmul_2(fsm_mmul_2), .fsm_done(fsm_done),
    .acc(acc), .carry(carry), .count(count), .ready(ready)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc <= cyc + 1;

  // Simple datapath stand-in: init loads v0, later steps add a per-step delta.
  always_comb begin
    if (fsm_init)                      dp_n_acc = v0;
    else if (fsm_msub_1 || fsm_macc_1) dp_n_acc = acc + v1;
    else if (fsm_mmul_2)               dp_n_acc = acc + v2;
    else                               dp_n_acc = acc + v3;
    dp_n_carry   = c_in;
    dp_ready     = 1'b1;
    mul_n_acc    = acc + 64'd3;
    mul_rem_zero = rz_mode ? (count == 6'd3) : rz_const;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: on each ready pulse, pop expectation, check latency and the
  // registered result just after the closing edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge g_clk);
      if (!g_reset && ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected none", cyc);
        end else begin
          it = sb.pop_front();
          chk({it.name, "_latency"}, 64'(cyc - it.start + 1), 64'(it.lat));
          @(posedge g_clk);
          #1;
          chk({it.name, "_acc"}, acc, it.acc);
          chk({it.name, "_carry"}, 64'(carry), 64'(it.carry));
          chk({it.name, "_count"}, 64'(count), 64'(it.cnt));
        end
      end
    end
  end

  // Issue one op, hold valid until ready, and track one step flag's timing.
  task automatic run_op(input string nm, input logic [3:0] uops,
                        input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] a2, input logic [63:0] a3, input logic cin,
                        input logic [63:0] e_acc, input logic e_carry, input logic [5:0] e_cnt,
                        input int e_lat, input int fsel, input int e_fcyc);
    exp_t it;
    bit   got;
    bit   f;
    int   fhits, fcyc;
    v0 = a0; v1 = a1; v2 = a2; v3 = a3; c_in = cin;
    {uop_madd, uop_msub, uop_macc, uop_mmul} = uops;
    valid = 1'b1;
    it.name = nm; it.acc = e_acc; it.carry = e_carry; it.cnt = e_cnt;
    it.lat = e_lat; it.start = cyc;
    sb.push_back(it);
    got = 1'b0; fhits = 0; fcyc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge g_clk);
      if (k == 1) chk({nm, "_init_flag"}, 64'(fsm_init), 64'd1);
      case (fsel)
        1:       f = fsm_msub_1;
        2:       f = fsm_macc_1;
        3:       f = fsm_mmul_2;
        default: f = 1'b0;
      endcase
      if (f) begin
        fhits++;
        if (fcyc == 0) fcyc = k;
      end
      if (ready) got = 1'b1;
      @(posedge g_clk);
      #1;
      if (got) break;
    end
    valid = 1'b0;
    {uop_madd, uop_msub, uop_macc, uop_mmul} = 4'b0000;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ready in 60 cycles expected ready", nm);
    end else if (fsel != 0) begin
      chk({nm, "_flag_cycle"}, 64'(fcyc), 64'(e_fcyc));
      chk({nm, "_flag_hits"}, 64'(fhits), 64'd1);
    end
  endtask

  initial begin
    g_reset = 1'b1; valid = 1'b0; flush = 1'b0;
    uop_madd = 1'b0; uop_msub = 1'b0; uop_macc = 1'b0; uop_mmul = 1'b0;
    v0 = '0; v1 = '0; v2 = '0; v3 = '0; c_in = 1'b0;
    rz_mode = 1'b0; rz_const = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("reset_acc", acc, 64'd0);
    chk("reset_carry", 64'(carry), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_flags", 64'({fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done}), 64'd0);
    g_reset = 1'b0;
    @(posedge g_clk);
    #1;

    run_op("madd", 4'b1000, 64'h1_0000_0000, 64'd0, 64'd0, 64'd0, 1'b0,
           64'h1_0000_0000, 1'b0, 6'd0, 1, 0, 0);
    run_op("msub", 4'b0100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0,
           64'd4, 1'b0, 6'd0, 3, 1, 2);
    run_op("macc", 4'b0010, 64'd10, 64'd7, 64'd0, 64'd0, 1'b1,
           64'd17, 1'b1, 6'd0, 3, 2, 2);
`ifdef XC_MALU_MUL_EARLY_EXIT_EN
    rz_const = 1'b0;
`else
    rz_const = 1'b1;
`endif
    run_op("mmul", 4'b0001, 64'd0, 64'd0, 64'hFFFF_FFFF, 64'h1_0000_0000, 1'b1,
           64'h2_0000_005F, 1'b1, 6'd32, 36, 3, 34);
    rz_const = 1'b0;
    run_op("madd_b2b", 4'b1000, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 64'd0, 1'b1,
           64'h1234_5678_9ABC_DEF0, 1'b1, 6'd0, 1, 0, 0);

    // Flush mid-multiply: three steps land, the flushed cycle writes nothing.
    c_in = 1'b0;
    uop_mmul = 1'b1; valid = 1'b1;
    repeat (4) @(posedge g_clk);
    #1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0; valid = 1'b0; uop_mmul = 1'b0;
    chk("flush_idle", 64'({fsm_mmul_1, fsm_mmul_2, fsm_done}), 64'd0);
    chk("flush_count", 64'(count), 64'd3);
    chk("flush_acc", acc, 64'd9);
    run_op("madd_after_flush", 4'b1000, 64'hDEAD, 64'd0, 64'd0, 64'd0, 1'b0,
           64'hDEAD, 1'b0, 6'd0, 1, 0, 0);

    // valid dropped in MSUB_1: back to IDLE without writing acc.
    v0 = 64'h55; v1 = 64'd1; c_in = 1'b0;
    uop_msub = 1'b1; valid = 1'b1;
    @(posedge g_clk);
    #1;
    valid = 1'b0;
    @(posedge g_clk);
    #1;
    uop_msub = 1'b0;
    chk("vdrop_idle", 64'({fsm_msub_1, fsm_done}), 64'd0);
    chk("vdrop_acc", acc, 64'h55);

    // Zero-hot request in IDLE does nothing.
    v0 = 64'hBAD; c_in = 1'b1; valid = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    valid = 1'b0;
    chk("zerohot_acc", acc, 64'h55);
    chk("zerohot_carry", 64'(carry), 64'd0);

`ifdef XC_MALU_MUL_EARLY_EXIT_EN
    rz_mode = 1'b1;
    run_op("mmul_early", 4'b0001, 64'd0, 64'd0, 64'hFFFF_FFFF, 64'h1_0000_0000, 1'b1,
           64'h2_0000_000B, 1'b1, 6'd4, 8, 3, 6);
    rz_mode = 1'b0;
`endif

    // Reset while the multiply loop is at count 10.
    uop_mmul = 1'b1; valid = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge g_clk);
        if (count == 6'd10) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) begin
        checks++;
        errors++;
        $display("FAIL midreset_reach: got count=%0d expected 10", count);
      end
    end
    g_reset = 1'b1; valid = 1'b0; uop_mmul = 1'b0;
    @(posedge g_clk);
    #1;
    chk("midreset_acc", acc, 64'd0);
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_ready", 64'(ready), 64'd0);
    chk("midreset_mmul1", 64'(fsm_mmul_1), 64'd0);
    g_reset = 1'b0;

    repeat (4) @(posedge g_clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
